// File: rtl/snr_ctrl_pkg.sv
// Shared state encoding and default tuning constants for the SNR calibration controller.
package snr_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CALIBRATE = 3'd1,
        SETTLE    = 3'd2,
        MONITOR   = 3'd3,
        FAULT     = 3'd4
    } snr_ctrl_state_t;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_SNR_WIDTH      = 16;
    localparam int DEF_CNT_WIDTH      = 16;
    localparam int DEF_CAL_SAMPLES    = 4096;
    localparam int DEF_SETTLE_SAMPLES = 64;
    localparam int DEF_ON_THRESH_DB   = 12;
    localparam int DEF_OFF_THRESH_DB  = 6;
    localparam int DEF_HOLD_SAMPLES   = 256;
    localparam int DEF_MIN_NOISE      = 1;
    localparam int DEF_MAX_RETRIES    = 3;

endpackage

// File: rtl/sample_window_counter.sv
// Saturating accepted-sample counter; o_done flags the sample that reaches the terminal count.
module sample_window_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic [CNT_WIDTH-1:0] i_terminal,
    output logic                 o_done
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_WIDTH'(1);
    assign o_done    = i_en && (w_cnt_inc == i_terminal);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_inc;
        end
    end

endmodule

// File: rtl/snr_calibration_controller.sv
// Calibration/settle/monitor sequencer with a debounced, hysteretic signal_present gate.
module snr_calibration_controller
    import snr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SNR_WIDTH      = DEF_SNR_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int CAL_SAMPLES    = DEF_CAL_SAMPLES,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
    parameter int ON_THRESH_DB   = DEF_ON_THRESH_DB,
    parameter int OFF_THRESH_DB  = DEF_OFF_THRESH_DB,
    parameter int HOLD_SAMPLES   = DEF_HOLD_SAMPLES,
    parameter int MIN_NOISE      = DEF_MIN_NOISE,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        recal_req,
    input  logic                        sample_valid,
    input  logic signed [SNR_WIDTH-1:0] snr_db,
    input  logic        [DATA_WIDTH-1:0] noise_rms,
    output logic                        quiet_period,
    output logic                        cal_done,
    output logic                        cal_fault,
    output logic                        signal_present,
    output logic        [2:0]           state_out
);

    localparam logic signed [SNR_WIDTH-1:0] ON_T  = SNR_WIDTH'(ON_THRESH_DB);
    localparam logic signed [SNR_WIDTH-1:0] OFF_T = SNR_WIDTH'(OFF_THRESH_DB);
    localparam logic [CNT_WIDTH-1:0]  CAL_T   = CNT_WIDTH'(CAL_SAMPLES);
    localparam logic [CNT_WIDTH-1:0]  SET_T   = CNT_WIDTH'(SETTLE_SAMPLES);
    localparam logic [CNT_WIDTH-1:0]  HOLD_T  = CNT_WIDTH'(HOLD_SAMPLES);
    localparam logic [CNT_WIDTH-1:0]  RETRY_T = CNT_WIDTH'(MAX_RETRIES);
    localparam logic [DATA_WIDTH-1:0] NOISE_T = DATA_WIDTH'(MIN_NOISE);

    snr_ctrl_state_t      r_state, w_next_state;
    logic [CNT_WIDTH-1:0] r_retries, w_retries_next;
    logic                 r_present, w_present_next;
    logic                 r_quiet, r_cal_done, r_cal_fault;

    logic                 w_in_window;
    logic                 w_win_en, w_win_clear, w_win_done;
    logic [CNT_WIDTH-1:0] w_win_terminal;
    logic                 w_hold_en, w_hold_clear, w_hold_done;
    logic                 w_above_on, w_below_off, w_noise_ok, w_last_retry;

    assign w_above_on   = (snr_db >= ON_T);
    assign w_below_off  = (snr_db < OFF_T);
    assign w_noise_ok   = (noise_rms >= NOISE_T);
    assign w_last_retry = ((r_retries + CNT_WIDTH'(1)) == RETRY_T);

    // One window counter serves both CALIBRATE and SETTLE; it restarts on every state change.
    assign w_in_window    = (r_state == CALIBRATE) || (r_state == SETTLE);
    assign w_win_en       = sample_valid && w_in_window;
    assign w_win_terminal = (r_state == SETTLE) ? SET_T : CAL_T;
    assign w_win_clear    = !w_in_window || w_win_done || (w_next_state != r_state);

    // Hold-off counts consecutive below-OFF samples while present; anything else restarts it.
    assign w_hold_en    = sample_valid && (r_state == MONITOR) && r_present && w_below_off;
    assign w_hold_clear = (r_state != MONITOR) || recal_req || !r_present ||
                          (sample_valid && !w_below_off) || w_hold_done;

    sample_window_counter #(.CNT_WIDTH(CNT_WIDTH)) u_window_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_win_clear),
        .i_en       (w_win_en),
        .i_terminal (w_win_terminal),
        .o_done     (w_win_done)
    );

    sample_window_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hold_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_hold_clear),
        .i_en       (w_hold_en),
        .i_terminal (HOLD_T),
        .o_done     (w_hold_done)
    );

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        w_next_state   = r_state;
        w_retries_next = r_retries;
        w_present_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state   = CALIBRATE;
                    w_retries_next = '0;
                end
            end
            CALIBRATE: begin
                if (w_win_done) begin
                    if (w_noise_ok) begin
                        w_next_state   = SETTLE;
                        w_retries_next = '0;
                    end else begin
                        w_retries_next = r_retries + CNT_WIDTH'(1);
                        if (w_last_retry) begin
                            w_next_state = FAULT;
                        end
                    end
                end
            end
            SETTLE: begin
                if (w_win_done) begin
                    w_next_state = MONITOR;
                end
            end
            MONITOR: begin
                if (recal_req) begin
                    w_next_state   = CALIBRATE;
                    w_retries_next = '0;
                end else begin
                    w_present_next = r_present;
                    if (!r_present && sample_valid && w_above_on) begin
                        w_present_next = 1'b1;
                    end else if (w_hold_done) begin
                        w_present_next = 1'b0;
                    end
                end
            end
            FAULT: begin
                if (recal_req) begin
                    w_next_state   = CALIBRATE;
                    w_retries_next = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decision so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_retries   <= '0;
            r_present   <= 1'b0;
            r_quiet     <= 1'b0;
            r_cal_done  <= 1'b0;
            r_cal_fault <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_retries   <= w_retries_next;
            r_present   <= w_present_next;
            r_quiet     <= (w_next_state == CALIBRATE);
            r_cal_done  <= (r_state == SETTLE) && (w_next_state == MONITOR);
            r_cal_fault <= (w_next_state == FAULT);
        end
    end

    assign quiet_period   = r_quiet;
    assign cal_done       = r_cal_done;
    assign cal_fault      = r_cal_fault;
    assign signal_present = r_present;
    assign state_out      = r_state;

endmodule
